// File: rtl/player_ctrl.sv
// Player column controller: synchronizes and debounces the left/right buttons, runs
// a direction FSM and steps btn_col at a fixed rate, clamped to the play field.
// Optional acceleration after ACCEL_STEPS consecutive steps: define PLAYER_ACCEL_EN.
module player_ctrl #(
  parameter logic [15:0] DB_CYCLES   = 16'd50000,
  parameter logic [19:0] MOVE_DIV    = 20'd262144,
  parameter int unsigned STEP_PIX    = 4,
  parameter logic [11:0] START_COL   = 12'd305,
  parameter logic [11:0] MIN_COL     = 12'd0,
  parameter logic [11:0] MAX_COL     = 12'd609,
  parameter int unsigned ACCEL_STEPS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_left,
  input  logic        btn_right,
  output logic [11:0] btn_col,
  output logic        moving,
  output logic        at_edge
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEFT,
    ST_RIGHT
  } state_e;

  // Button vectors: bit 0 = left, bit 1 = right.
  logic [1:0]       sync1_q;
  logic [1:0]       sync2_q;
  logic [1:0]       deb_q, deb_d;
  logic [1:0][15:0] db_cnt_q, db_cnt_d;

  state_e      state_q, state_d;
  logic [19:0] timer_q, timer_d;
  logic [11:0] col_q, col_d;
  logic        moving_q, moving_d;
  logic        at_edge_q, at_edge_d;

  logic        step_fire;
  logic        state_change;
  logic [12:0] step;
  logic [12:0] col_ext;
  logic [12:0] min_ext;
  logic [12:0] max_ext;

  assign col_ext = {1'b0, col_q};
  assign min_ext = {1'b0, MIN_COL};
  assign max_ext = {1'b0, MAX_COL};

  // ---------------------------------------------------------------- debounce
  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DB_CYCLES - 16'd1) begin
          deb_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 16'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- direction FSM
  always_comb begin
    state_d = ST_IDLE;
    case (deb_q)
      2'b01:   state_d = ST_LEFT;
      2'b10:   state_d = ST_RIGHT;
      default: state_d = ST_IDLE;
    endcase
  end

  assign state_change = (state_d != state_q);

  // Timer sits at 0 on entry, so the first step lands on the first clock in LEFT/RIGHT.
  assign step_fire = (state_q != ST_IDLE) && (timer_q == '0);

  always_comb begin
    timer_d = '0;
    if (!state_change && (state_q != ST_IDLE)) begin
      if (timer_q == MOVE_DIV - 20'd1) begin
        timer_d = '0;
      end else begin
        timer_d = timer_q + 20'd1;
      end
    end
  end

  // ---------------------------------------------------------------- step size
`ifdef PLAYER_ACCEL_EN
  localparam int unsigned ACC_W = $clog2(ACCEL_STEPS + 1);
  localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(ACCEL_STEPS);

  logic [ACC_W-1:0] acc_cnt_q, acc_cnt_d;

  always_comb begin
    acc_cnt_d = acc_cnt_q;
    if (state_change) begin
      acc_cnt_d = '0;
    end else if (step_fire && (acc_cnt_q != ACC_MAX)) begin
      acc_cnt_d = acc_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt_q <= '0;
    end else begin
      acc_cnt_q <= acc_cnt_d;
    end
  end

  assign step = (acc_cnt_q == ACC_MAX) ? 13'(2 * STEP_PIX) : 13'(STEP_PIX);
`else
  assign step = 13'(STEP_PIX);
`endif

  // ---------------------------------------------------------------- column update
  // 13-bit compare keeps the clamp free of underflow/overflow wrap-around.
  always_comb begin
    col_d = col_q;
    if (step_fire) begin
      if (state_q == ST_LEFT) begin
        if (col_ext < min_ext + step) begin
          col_d = MIN_COL;
        end else begin
          col_d = 12'(col_ext - step);
        end
      end else begin
        if (col_ext + step > max_ext) begin
          col_d = MAX_COL;
        end else begin
          col_d = 12'(col_ext + step);
        end
      end
    end
  end

  assign moving_d  = (state_d != ST_IDLE);
  assign at_edge_d = (col_d == MIN_COL) || (col_d == MAX_COL);

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      db_cnt_q  <= '0;
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      col_q     <= START_COL;
      moving_q  <= 1'b0;
      at_edge_q <= 1'b0;
    end else begin
      sync1_q   <= {btn_right, btn_left};
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      db_cnt_q  <= db_cnt_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      col_q     <= col_d;
      moving_q  <= moving_d;
      at_edge_q <= at_edge_d;
    end
  end

  assign btn_col = col_q;
  assign moving  = moving_q;
  assign at_edge = at_edge_q;

endmodule

// File: tb/tb_player_ctrl.sv
// Self-checking bench for player_ctrl with a behavioural reference model.
module tb_player_ctrl;

  localparam int DB    = 4;
  localparam int MD    = 8;
  localparam int STEP  = 4;
  localparam int START = 305;
  localparam int MINC  = 0;
  localparam int MAXC  = 609;
  localparam int ACCEL = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_left;
  logic        btn_right;
  logic [11:0] btn_col;
  logic        moving;
  logic        at_edge;

  int checks = 0;
  int errors = 0;

  player_ctrl #(
    .DB_CYCLES(16'd4),
    .MOVE_DIV (20'd8),
    .STEP_PIX (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_left (btn_left),
    .btn_right(btn_right),
    .btn_col  (btn_col),
    .moving   (moving),
    .at_edge  (at_edge)
  );

  always #5 clk = ~clk;

  // Reference model: direction 0 = none, 1 = left, 2 = right.
  int m_col   = START;
  int m_dir   = 0;
  int m_age   = 0;   // clocks spent in current direction
  int m_steps = 0;   // steps taken in current direction
  bit m_deb_l = 0;
  bit m_deb_r = 0;
  bit pipe_l[$];     // raw samples in flight through the 2-clock synchronizer
  bit pipe_r[$];
  bit win_l[$];      // last DB synchronized samples seen by the debouncer
  bit win_r[$];

  function automatic bit stable_at(input bit w[$], input bit v);
    if (w.size() < DB) return 1'b0;
    foreach (w[i]) if (w[i] != v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_col = START; m_dir = 0; m_age = 0; m_steps = 0;
    m_deb_l = 0; m_deb_r = 0;
    pipe_l = '{0, 0}; pipe_r = '{0, 0};
    win_l.delete(); win_r.delete();
  endtask

  task automatic model_edge(input bit l, input bit r, input bit rs);
    int stp;
    int ndir;
    bit seen_l, seen_r;
    if (rs) begin
      model_reset();
      return;
    end
    // A step occurs every MD clocks from the moment a direction is entered.
    if (m_dir != 0 && (m_age % MD) == 0) begin
      stp = STEP;
`ifdef PLAYER_ACCEL_EN
      if (m_steps >= ACCEL) stp = 2 * STEP;
`endif
      if (m_dir == 1) m_col = (m_col - stp < MINC) ? MINC : m_col - stp;
      else            m_col = (m_col + stp > MAXC) ? MAXC : m_col + stp;
      m_steps++;
    end
    ndir = (m_deb_l && !m_deb_r) ? 1 : (!m_deb_l && m_deb_r) ? 2 : 0;
    if (ndir != m_dir) begin
      m_age = 0; m_steps = 0;
    end else begin
      m_age++;
    end
    m_dir = ndir;
    seen_l = pipe_l.pop_front(); pipe_l.push_back(l);
    seen_r = pipe_r.pop_front(); pipe_r.push_back(r);
    win_l.push_back(seen_l); if (win_l.size() > DB) void'(win_l.pop_front());
    win_r.push_back(seen_r); if (win_r.size() > DB) void'(win_r.pop_front());
    if (stable_at(win_l, !m_deb_l)) m_deb_l = !m_deb_l;
    if (stable_at(win_r, !m_deb_r)) m_deb_r = !m_deb_r;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input bit l, input bit r, input bit rs);
    btn_left = l; btn_right = r; rst = rs;
    @(posedge clk);
    model_edge(l, r, rs);
    #1;
    chk("model_col", 32'(btn_col), 32'(m_col));
    chk("model_moving", 32'(moving), 32'(m_dir != 0));
    chk("model_at_edge", 32'(at_edge), 32'(m_col == MINC || m_col == MAXC));
  endtask

  task automatic do_reset();
    tick(0, 0, 1);
    tick(0, 0, 1);
  endtask

  initial begin
    bit rl, rr;
    btn_left = 0; btn_right = 0; rst = 1;
    model_reset();

    // Reset state
    do_reset();
    chk("reset_col", 32'(btn_col), 32'd305);
    chk("reset_moving", 32'(moving), 32'd0);
    chk("reset_at_edge", 32'(at_edge), 32'd0);

    // Hold right: first step 8 clocks after the raw edge, then every 8
    repeat (7) tick(0, 1, 0);
    chk("t1_col_before_step", 32'(btn_col), 32'd305);
    chk("t1_moving_early", 32'(moving), 32'd1);
    tick(0, 1, 0);
    chk("t1_first_step", 32'(btn_col), 32'd309);
    repeat (8) tick(0, 1, 0);
    chk("t1_second_step", 32'(btn_col), 32'd313);
    repeat (8) tick(0, 1, 0);
    chk("t1_third_step", 32'(btn_col), 32'd317);

    // Short glitch on left is filtered
    do_reset();
    repeat (5) tick(0, 0, 0);
    repeat (3) tick(1, 0, 0);
    repeat (20) tick(0, 0, 0);
    chk("t2_glitch_col", 32'(btn_col), 32'd305);
    chk("t2_glitch_moving", 32'(moving), 32'd0);

    // Hold left to the left clamp
    do_reset();
    repeat (700) tick(1, 0, 0);
    chk("t3_left_clamp", 32'(btn_col), 32'd0);
    chk("t3_left_edge", 32'(at_edge), 32'd1);
    chk("t3_left_moving", 32'(moving), 32'd1);

    // Hold right to the right clamp
    do_reset();
    repeat (600) tick(0, 1, 0);
`ifndef PLAYER_ACCEL_EN
    chk("t4_before_clamp", 32'(btn_col), 32'd605);
`endif
    repeat (100) tick(0, 1, 0);
    chk("t4_right_clamp", 32'(btn_col), 32'd609);
    chk("t4_right_edge", 32'(at_edge), 32'd1);

    // Both held -> idle; releasing left steps right right after debounce
    do_reset();
    repeat (20) tick(1, 1, 0);
    chk("t5_both_col", 32'(btn_col), 32'd305);
    chk("t5_both_moving", 32'(moving), 32'd0);
    repeat (7) tick(0, 1, 0);
    chk("t5_release_pre", 32'(btn_col), 32'd305);
    tick(0, 1, 0);
    chk("t5_release_step", 32'(btn_col), 32'd309);

    // Reset mid-move
    do_reset();
`ifdef PLAYER_ACCEL_EN
    repeat (64) tick(0, 1, 0);
    chk("t6_accel_337", 32'(btn_col), 32'd337);
    repeat (8) tick(0, 1, 0);
    chk("t6_accel_345", 32'(btn_col), 32'd345);
    repeat (8) tick(0, 1, 0);
    chk("t6_accel_353", 32'(btn_col), 32'd353);
`else
    repeat (72) tick(0, 1, 0);
    chk("t6_at_341", 32'(btn_col), 32'd341);
`endif
    tick(0, 1, 1);
    chk("t6_reset_col", 32'(btn_col), 32'd305);
    chk("t6_reset_moving", 32'(moving), 32'd0);
    repeat (8) tick(0, 1, 0);
    chk("t6_press_after_reset", 32'(btn_col), 32'd309);

    // Randomized: button levels change occasionally, giving glitches and long holds
    rl = 0; rr = 0;
    for (int n = 0; n < 8000; n++) begin
      if ($urandom_range(0, 9) == 0) rl = !rl;
      if ($urandom_range(0, 9) == 0) rr = !rr;
      if ($urandom_range(0, 63) == 0) begin
        rl = $urandom_range(0, 1) == 1;
        rr = 0;
        repeat ($urandom_range(20, 400)) tick(rl, rr, 0);
      end
      tick(rl, rr, $urandom_range(0, 2999) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
